// File: rtl/mul_alu_sched.sv
// mul_alu_sched: shift-add multiply sequencer that borrows the shared execute-stage ALU.
// While idle the pipeline's ALU request passes straight through. Once a multiply starts,
// the sequencer owns the ALU for WIDTH add/shift cycles and stalls the pipeline, then
// spends one DONE cycle presenting the product.
// Optional feature: define MUL_ZERO_BYPASS_EN to skip the RUN phase when either operand is
// zero, so the zero product is ready one cycle after the start.
module mul_alu_sched #(
  parameter int         WIDTH    = 16,
  parameter logic [3:0] ADD_CODE = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ex_ctrl,
  input  logic [WIDTH-1:0] ex_a,
  input  logic [WIDTH-1:0] ex_b,
  input  logic             mul_start,
  input  logic [WIDTH-1:0] mul_a,
  input  logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_cout,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             ex_stall,
  output logic             mul_busy,
  output logic             mul_done,
  output logic [WIDTH-1:0] mul_hi,
  output logic [WIDTH-1:0] mul_lo
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] cnt;
  logic             start_ok;
  logic             zero_ops;

  // A start is only honoured from IDLE; requests while busy are dropped.
  assign start_ok = (state == IDLE) && mul_start;

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_ops = (mul_a == '0) || (mul_b == '0);
`else
  assign zero_ops = 1'b0;
`endif

  // The accumulator pair doubles as the product register; it is untouched after DONE,
  // so the result holds until the next accepted start.
  assign mul_hi = acc_hi;
  assign mul_lo = acc_lo;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic plus ALU steering and status outputs.
  always_comb begin
    state_nxt = state;
    alu_ctrl  = ex_ctrl;
    alu_a     = ex_a;
    alu_b     = ex_b;
    ex_stall  = 1'b0;
    mul_busy  = 1'b0;
    mul_done  = 1'b0;
    unique case (state)
      IDLE: begin
        // The issuing instruction completes in the start cycle, so no stall here.
        if (start_ok) state_nxt = zero_ops ? DONE : RUN;
      end
      RUN: begin
        alu_ctrl = ADD_CODE;
        alu_a    = acc_hi;
        alu_b    = acc_lo[0] ? mcand : '0;
        ex_stall = 1'b1;
        mul_busy = 1'b1;
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        ex_stall  = 1'b1;
        mul_busy  = 1'b1;
        mul_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on start, then one multiplier bit consumed per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else if (start_ok) begin
      mcand  <= mul_a;
      acc_hi <= '0;
      acc_lo <= zero_ops ? '0 : mul_b;
      cnt    <= '0;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      // The ALU carry becomes the top bit of the shifted partial product.
      if (acc_lo[0]) begin
        {acc_hi, acc_lo} <= {alu_cout, alu_res, acc_lo[WIDTH-1:1]};
      end else begin
        {acc_hi, acc_lo} <= {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_mul_alu_sched.sv
// Testbench for mul_alu_sched: models the shared ALU, drives directed and random multiplies,
// and compares product, latency and stall behaviour against plain arithmetic.
module tb_mul_alu_sched;

  localparam int         WIDTH    = 16;
  localparam logic [3:0] ADD_CODE = 4'b0000;
`ifdef MUL_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       ex_ctrl;
  logic [WIDTH-1:0] ex_a, ex_b;
  logic             mul_start;
  logic [WIDTH-1:0] mul_a, mul_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic             ex_stall, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_hi, mul_lo;

  int tests = 0;
  int fails = 0;

  mul_alu_sched #(.WIDTH(WIDTH), .ADD_CODE(ADD_CODE)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .alu_res(alu_res), .alu_cout(alu_cout),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .ex_stall(ex_stall), .mul_busy(mul_busy), .mul_done(mul_done),
    .mul_hi(mul_hi), .mul_lo(mul_lo)
  );

  always #5 clk = ~clk;

  // Shared ALU model: ADD with carry-out for ADD_CODE, XOR for anything else.
  logic [WIDTH:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    if (alu_ctrl == ADD_CODE) alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    else                      alu_sum = {1'b0, alu_a ^ alu_b};
  end
  assign alu_res  = alu_sum[WIDTH-1:0];
  assign alu_cout = alu_sum[WIDTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and return at the falling edge, where outputs are stable.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one multiply and follow it to completion. inject_at > 0 pulses a second start
  // with fresh operands on that cycle of the run.
  task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int inject_at);
    logic [31:0] pa, pb, prod;
    int n, exp_lat, pulses;
    bit stall_ok;
    pa = {16'h0, a};
    pb = {16'h0, b};
    prod = pa * pb;
    exp_lat = (BYPASS && (a == '0 || b == '0)) ? 1 : WIDTH + 1;
    mul_a = a; mul_b = b; mul_start = 1'b1;
    chk("start_no_stall", {31'h0, ex_stall}, 32'h0);
    tick();
    mul_start = 1'b0;
    mul_a = WIDTH'($urandom); mul_b = WIDTH'($urandom);
    n = 1; stall_ok = 1'b1;
    while (!mul_done && n < 3 * WIDTH) begin
      if (!ex_stall || !mul_busy) stall_ok = 1'b0;
      if (n == 2) begin
        ex_ctrl = 4'b0111;
        #1 chk("run_alu_ctrl_add", {28'h0, alu_ctrl}, {28'h0, ADD_CODE});
      end
      if (n == inject_at) begin
        mul_start = 1'b1;
        mul_a = WIDTH'($urandom) | 16'h1;
        mul_b = WIDTH'($urandom) | 16'h1;
      end
      tick();
      if (n == inject_at) mul_start = 1'b0;
      n++;
    end
    chk("done_latency", n, exp_lat);
    chk("done_pulse", {31'h0, mul_done}, 32'h1);
    chk("done_stall", {31'h0, ex_stall}, 32'h1);
    chk("run_stall_busy", {31'h0, stall_ok}, 32'h1);
    chk("product", {mul_hi, mul_lo}, prod);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mul_done) pulses++;
    end
    chk("single_done", pulses, 0);
    chk("idle_busy", {31'h0, mul_busy}, 32'h0);
    chk("idle_stall", {31'h0, ex_stall}, 32'h0);
    chk("product_held", {mul_hi, mul_lo}, prod);
  endtask

  initial begin
    rst_n = 1'b0; mul_start = 1'b0; mul_a = '0; mul_b = '0;
    ex_ctrl = '0; ex_a = '0; ex_b = '0;
    #12;
    chk("rst_busy", {31'h0, mul_busy}, 32'h0);
    chk("rst_done", {31'h0, mul_done}, 32'h0);
    chk("rst_stall", {31'h0, ex_stall}, 32'h0);
    chk("rst_product", {mul_hi, mul_lo}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Idle passthrough, directed then random.
    ex_ctrl = 4'b0101; ex_a = 16'h1234; ex_b = 16'h0004;
    #1;
    chk("pass_ctrl", {28'h0, alu_ctrl}, 32'h5);
    chk("pass_a", {16'h0, alu_a}, 32'h1234);
    chk("pass_b", {16'h0, alu_b}, 32'h0004);
    chk("pass_stall", {31'h0, ex_stall}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      ex_ctrl = 4'($urandom); ex_a = WIDTH'($urandom); ex_b = WIDTH'($urandom);
      #1;
      chk("pass_rand", {alu_ctrl, alu_a[11:0], alu_b}, {ex_ctrl, ex_a[11:0], ex_b});
    end
    tick();

    // Directed products, including the carry-heavy all-ones case and a zero operand.
    run_mul(16'h0003, 16'h0005, 0);
    run_mul(16'hFFFF, 16'hFFFF, 0);
    run_mul(16'h0000, 16'h1234, 0);
    run_mul(16'h1234, 16'h0000, 0);
    // Start during a run must be ignored.
    run_mul(16'hABCD, 16'h1357, 5);
    // Random operands.
    for (int i = 0; i < 6; i++) begin
      run_mul(WIDTH'($urandom), WIDTH'($urandom), 0);
    end

    // Reset mid-run drops everything immediately.
    mul_a = 16'h0003; mul_b = 16'h0005; mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_busy", {31'h0, mul_busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'h0, mul_busy}, 32'h0);
    chk("midrst_stall", {31'h0, ex_stall}, 32'h0);
    chk("midrst_done", {31'h0, mul_done}, 32'h0);
    chk("midrst_product", {mul_hi, mul_lo}, 32'h0);
    chk("midrst_pass", {16'h0, alu_a}, {16'h0, ex_a});
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_mul(16'h0003, 16'h0005, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
